// File: rtl/sram_nr1w_bw_pkg.sv
// sram_nr1w_bw_pkg: shared types and helpers for the multi-read byte-write SRAM.
//   clr_st_e  : clear-sweep FSM state (ST_IDLE / ST_CLEAR)
//   sram_nsel : number of byte lanes for a given data width
package sram_nr1w_bw_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_st_e;

  function automatic int unsigned sram_nsel(input int unsigned wid);
    return wid / 8;
  endfunction

endpackage

// File: rtl/sram_bank_1r1w.sv
// sram_bank_1r1w: one inferred 1-write/1-read bank with byte write enables.
// Ports:
//   clk, rst         : clock, async active-high reset (output register only)
//   wr, sel, wadr, i : write strobe, byte enables, address, data
//   rd, radr         : read enable and address
//   o                : raw read data, one cycle after rd, old contents on a
//                      same-address write (no forwarding here)
module sram_bank_1r1w #(
  parameter int unsigned WID  = 512,
  parameter int unsigned DEP  = 256,
  parameter int unsigned AW   = $clog2(DEP),
  parameter int unsigned NSEL = WID / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [NSEL-1:0] sel,
  input  logic [AW-1:0]   wadr,
  input  logic [WID-1:0]  i,
  input  logic            rd,
  input  logic [AW-1:0]   radr,
  output logic [WID-1:0]  o
);

  logic [WID-1:0] r_mem [DEP];
  logic [WID-1:0] r_o;

  // Array kept reset-free so it infers as RAM.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int b = 0; b < NSEL; b++) begin
        if (sel[b]) r_mem[wadr][8*b +: 8] <= i[8*b +: 8];
      end
    end
  end

  // Read enable gates the register so the value holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o <= '0;
    end else if (rd) begin
      r_o <= r_mem[radr];
    end
  end

  assign o = r_o;

endmodule

// File: rtl/sram_nr1w_bw.sv
// sram_nr1w_bw: NRD-read / 1-write SRAM with byte enables, per-byte write-first
// forwarding, read latency 1 or 2 and an optional post-reset zeroing sweep.
// Ports:
//   rst, clk            : async active-high reset, clock
//   busy                : clear sweep running; wr/rd ignored
//   wr, sel, wadr, i    : write port (byte enables in sel)
//   rd, radr            : per-port read request / address (slice k*AW)
//   o, ov               : per-port read data (slice k*WID) and valid pulse
module sram_nr1w_bw
  import sram_nr1w_bw_pkg::*;
#(
  parameter int unsigned WID        = 512,
  parameter int unsigned DEP        = 256,
  parameter int unsigned NRD        = 2,
  parameter int unsigned RLAT       = 1,
  parameter int unsigned CLR_ON_RST = 1,
  localparam int unsigned NSEL      = sram_nsel(WID),
  localparam int unsigned AW        = $clog2(DEP)
) (
  input  logic              rst,
  input  logic              clk,
  output logic              busy,
  input  logic              wr,
  input  logic [NSEL-1:0]   sel,
  input  logic [AW-1:0]     wadr,
  input  logic [WID-1:0]    i,
  input  logic [NRD-1:0]    rd,
  input  logic [NRD*AW-1:0] radr,
  output logic [NRD*WID-1:0] o,
  output logic [NRD-1:0]    ov
);

  if (RLAT != 1 && RLAT != 2) begin : g_bad_rlat
    $error("sram_nr1w_bw: RLAT must be 1 or 2");
  end
  if (WID == 0 || (WID % 8) != 0) begin : g_bad_wid
    $error("sram_nr1w_bw: WID must be a non-zero multiple of 8");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("sram_nr1w_bw: NRD must be 1..4");
  end
  if (DEP < 4 || (DEP & (DEP - 1)) != 0) begin : g_bad_dep
    $error("sram_nr1w_bw: DEP must be a power of 2 and at least 4");
  end

  // Clear FSM
  clr_st_e       r_state;
  logic          r_busy;
  logic [AW-1:0] r_clr_adr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      r_busy    <= (CLR_ON_RST != 0);
      r_clr_adr <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_adr <= r_clr_adr + AW'(1);
          if (r_clr_adr == AW'(DEP - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;

  // Shared bank write port: sweep owns it while busy.
  logic            w_bwr;
  logic [NSEL-1:0] w_bsel;
  logic [AW-1:0]   w_bwadr;
  logic [WID-1:0]  w_bdat;

  assign w_bwr   = r_busy | wr;
  assign w_bsel  = r_busy ? '1 : sel;
  assign w_bwadr = r_busy ? r_clr_adr : wadr;
  assign w_bdat  = r_busy ? '0 : i;

  // Read acceptance and same-cycle write hit per port
  logic [AW-1:0]  w_radr [NRD];
  logic [NRD-1:0] w_acc;
  logic [NRD-1:0] w_hit;

  always_comb begin
    w_radr = '{default: '0};
    w_acc  = '0;
    w_hit  = '0;
    for (int k = 0; k < NRD; k++) begin
      w_radr[k] = radr[k*AW +: AW];
      w_acc[k]  = rd[k] & ~r_busy;
      w_hit[k]  = w_acc[k] & wr & (w_radr[k] == wadr);
    end
  end

  logic [WID-1:0] w_raw [NRD];

  for (genvar k = 0; k < NRD; k++) begin : g_bank
    sram_bank_1r1w #(
      .WID  (WID),
      .DEP  (DEP),
      .AW   (AW),
      .NSEL (NSEL)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .wr   (w_bwr),
      .sel  (w_bsel),
      .wadr (w_bwadr),
      .i    (w_bdat),
      .rd   (w_acc[k]),
      .radr (w_radr[k]),
      .o    (w_raw[k])
    );
  end

  // Write sel/data/hit captured with the read so later writes cannot leak in.
  logic [NRD-1:0]  r_v1;
  logic [NRD-1:0]  r_hit;
  logic [NSEL-1:0] r_fsel [NRD];
  logic [WID-1:0]  r_fdat [NRD];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= '0;
      r_hit <= '0;
      for (int k = 0; k < NRD; k++) begin
        r_fsel[k] <= '0;
        r_fdat[k] <= '0;
      end
    end else begin
      r_v1 <= w_acc;
      for (int k = 0; k < NRD; k++) begin
        if (w_acc[k]) begin
          r_hit[k]  <= w_hit[k];
          r_fsel[k] <= sel;
          r_fdat[k] <= i;
        end
      end
    end
  end

  logic [WID-1:0] w_fwd [NRD];

  always_comb begin
    w_fwd = '{default: '0};
    for (int k = 0; k < NRD; k++) begin
      for (int b = 0; b < NSEL; b++) begin
        w_fwd[k][8*b +: 8] = (r_hit[k] && r_fsel[k][b]) ? r_fdat[k][8*b +: 8]
                                                        : w_raw[k][8*b +: 8];
      end
    end
  end

  if (RLAT == 2) begin : g_lat2
    logic [WID-1:0] r_o2 [NRD];
    logic [NRD-1:0] r_v2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v2 <= '0;
        for (int k = 0; k < NRD; k++) r_o2[k] <= '0;
      end else begin
        r_v2 <= r_v1;
        for (int k = 0; k < NRD; k++) begin
          if (r_v1[k]) r_o2[k] <= w_fwd[k];
        end
      end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_o
      assign o[k*WID +: WID] = r_o2[k];
    end
    assign ov = r_v2;
  end else begin : g_lat1
    // Bank output and forward registers only change on an accepted read,
    // so the combinational mux holds its value between reads.
    for (genvar k = 0; k < NRD; k++) begin : g_o
      assign o[k*WID +: WID] = w_fwd[k];
    end
    assign ov = r_v1;
  end

endmodule

// File: tb/tb_sram_nr1w_bw.sv
// Bench for sram_nr1w_bw: an RLAT=1 and an RLAT=2 instance share all inputs.
// A reference memory model produces expected read data at issue time; a
// negedge monitor pops and compares when each read is due.
module tb_sram_nr1w_bw;

  localparam int unsigned WID  = 64;
  localparam int unsigned DEP  = 256;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NSEL = WID / 8;
  localparam int unsigned AW   = $clog2(DEP);

  typedef struct packed {
    int unsigned    due;
    logic [WID-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr = 1'b0;
  logic [NSEL-1:0]    sel = '0;
  logic [AW-1:0]      wadr = '0;
  logic [WID-1:0]     din = '0;
  logic [NRD-1:0]     rd = '0;
  logic [NRD*AW-1:0]  radr = '0;
  logic               busy1, busy2;
  logic [NRD*WID-1:0] o1, o2;
  logic [NRD-1:0]     ov1, ov2;

  always #5 clk = ~clk;

  sram_nr1w_bw #(.WID(WID), .DEP(DEP), .NRD(NRD), .RLAT(1), .CLR_ON_RST(1)) u_dut1 (
    .rst(rst), .clk(clk), .busy(busy1), .wr(wr), .sel(sel), .wadr(wadr), .i(din),
    .rd(rd), .radr(radr), .o(o1), .ov(ov1)
  );

  sram_nr1w_bw #(.WID(WID), .DEP(DEP), .NRD(NRD), .RLAT(2), .CLR_ON_RST(1)) u_dut2 (
    .rst(rst), .clk(clk), .busy(busy2), .wr(wr), .sel(sel), .wadr(wadr), .i(din),
    .rd(rd), .radr(radr), .o(o2), .ov(ov2)
  );

  int             checks = 0;
  int             failures = 0;
  logic [WID-1:0] model [DEP];
  int unsigned    busy_left = 0;
  int unsigned    ecnt = 0;
  bit             mon_en = 1'b0;
  exp_t           q1 [NRD][$];
  exp_t           q2 [NRD][$];
  logic [WID-1:0] last1 [NRD];
  logic [WID-1:0] last2 [NRD];

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (busy1 !== (busy_left != 0) || busy2 !== (busy_left != 0)) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b/%b want=%b", ecnt, busy1, busy2, busy_left != 0);
      end
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (q1[k].size() > 0 && q1[k][0].due == ecnt) begin
          if (ov1[k] !== 1'b1 || o1[k*WID +: WID] !== q1[k][0].data) begin
            failures++;
            $display("FAIL rlat1_read port%0d cyc=%0d got ov=%b o=%h want ov=1 o=%h",
                     k, ecnt, ov1[k], o1[k*WID +: WID], q1[k][0].data);
          end
          last1[k] = q1[k][0].data;
          void'(q1[k].pop_front());
        end else if (ov1[k] !== 1'b0 || o1[k*WID +: WID] !== last1[k]) begin
          failures++;
          $display("FAIL rlat1_hold port%0d cyc=%0d got ov=%b o=%h want ov=0 o=%h",
                   k, ecnt, ov1[k], o1[k*WID +: WID], last1[k]);
        end
        checks++;
        if (q2[k].size() > 0 && q2[k][0].due == ecnt) begin
          if (ov2[k] !== 1'b1 || o2[k*WID +: WID] !== q2[k][0].data) begin
            failures++;
            $display("FAIL rlat2_read port%0d cyc=%0d got ov=%b o=%h want ov=1 o=%h",
                     k, ecnt, ov2[k], o2[k*WID +: WID], q2[k][0].data);
          end
          last2[k] = q2[k][0].data;
          void'(q2[k].pop_front());
        end else if (ov2[k] !== 1'b0 || o2[k*WID +: WID] !== last2[k]) begin
          failures++;
          $display("FAIL rlat2_hold port%0d cyc=%0d got ov=%b o=%h want ov=0 o=%h",
                   k, ecnt, ov2[k], o2[k*WID +: WID], last2[k]);
        end
      end
    end
  end

  // One clock: drive inputs, update model at the edge, push expected reads.
  task automatic step(input logic w, input logic [NSEL-1:0] s, input logic [AW-1:0] wa,
                      input logic [WID-1:0] d, input logic [NRD-1:0] r,
                      input logic [NRD*AW-1:0] ra);
    logic [WID-1:0] e;
    logic [AW-1:0]  a;
    bit             acc;
    wr = w; sel = s; wadr = wa; din = d; rd = r; radr = ra;
    @(posedge clk);
    ecnt++;
    acc = (busy_left == 0);
    if (!acc) busy_left--;
    if (acc) begin
      for (int k = 0; k < NRD; k++) begin
        if (r[k]) begin
          a = ra[k*AW +: AW];
          e = model[a];
          if (w && wa == a) begin
            for (int b = 0; b < NSEL; b++) if (s[b]) e[8*b +: 8] = d[8*b +: 8];
          end
          q1[k].push_back('{due: ecnt, data: e});
          q2[k].push_back('{due: ecnt + 1, data: e});
        end
      end
      if (w) begin
        for (int b = 0; b < NSEL; b++) if (s[b]) model[wa][8*b +: 8] = d[8*b +: 8];
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic assert_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    wr = 1'b0; rd = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      q1[k].delete(); q2[k].delete();
      last1[k] = '0; last2[k] = '0;
    end
    for (int a = 0; a < DEP; a++) model[a] = '0;
    busy_left = DEP;
    mon_en = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (o1 !== '0 || ov1 !== '0 || o2 !== '0 || ov2 !== '0 || busy1 !== 1'b1
        || busy2 !== 1'b1) begin
      failures++;
      $display("FAIL %s got o1=%h ov1=%b o2=%h ov2=%b busy=%b/%b want o=0 ov=0 busy=1",
               tag, o1, ov1, o2, ov2, busy1, busy2);
    end
  endtask

  // Counts busy cycles while hammering the ports; all accesses must be ignored.
  task automatic count_busy(input string tag);
    int cnt = 0;
    while (busy1 === 1'b1 && cnt < 2 * DEP) begin
      cnt++;
      step(1'b1, '1, 8'h10, '1, 2'b11, {8'h10, 8'h10});
    end
    checks++;
    if (cnt != DEP) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", tag, cnt, DEP);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    release_reset();
    count_busy("reset_sweep");
    step(1'b0, '0, '0, '0, 2'b11, {8'h7F, 8'h00});
    step(1'b0, '0, '0, '0, 2'b11, {8'h10, 8'hFF});
    idle(3);
  endtask

  task automatic test_byte_write();
    step(1'b1, '1, 8'd5, '1, '0, '0);
    step(1'b1, 8'hF0, 8'd5, '0, '0, '0);
    step(1'b0, '0, '0, '0, 2'b01, {8'd0, 8'd5});
    idle(3);
  endtask

  task automatic test_forward();
    step(1'b1, '1, 8'd9, {8{8'hAA}}, '0, '0);
    step(1'b1, 8'h01, 8'd9, {8{8'h55}}, 2'b01, {8'd0, 8'd9});
    step(1'b1, '1, 8'd9, {8{8'h33}}, '0, '0);
    idle(2);
    step(1'b0, '0, '0, '0, 2'b01, {8'd0, 8'd9});
    idle(3);
  endtask

  task automatic test_multiport();
    step(1'b1, '1, 8'd3, 64'hDEAD_BEEF_0123_4567, '0, '0);
    step(1'b1, 8'h3C, 8'd9, 64'h1122_3344_5566_7788, 2'b11, {8'd9, 8'd3});
    step(1'b1, 8'h81, 8'd9, 64'hCAFE_F00D_0BAD_BEEF, 2'b11, {8'd9, 8'd9});
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++) step(1'b1, '1, AW'(a), {8{8'(a * 17 + 1)}}, '0, '0);
    for (int a = 0; a < 8; a++)
      step(1'b1, '1, 8'd40, {8{8'(a)}}, 2'b11, {AW'(7 - a), AW'(a)});
    idle(4);
  endtask

  task automatic test_reset_mid();
    step(1'b0, '0, '0, '0, 2'b11, {8'd9, 8'd5});
    assert_reset();
    #1;
    check_reset_outputs("reset_inflight");
    release_reset();
    idle(100);
    assert_reset();
    #1;
    check_reset_outputs("reset_midsweep");
    release_reset();
    count_busy("resweep");
    step(1'b0, '0, '0, '0, 2'b11, {8'd9, 8'd5});
    step(1'b0, '0, '0, '0, 2'b11, {8'd40, 8'd3});
    idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte_write();
    test_forward();
    test_multiport();
    test_back_to_back();
    test_reset_mid();
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (q1[k].size() != 0 || q2[k].size() != 0) begin
        failures++;
        $display("FAIL drain port%0d pending got=%0d/%0d want=0/0",
                 k, q1[k].size(), q2[k].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
